// File: rtl/err_eval_pkg.sv
// Shared types and width helpers for the error-metric accumulator.
package err_eval_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_e;

  function automatic int max_w(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sum_w(int w, int n);
    return w + n;
  endfunction

  function automatic int sq_w(int w, int n);
    return 2 * w + n;
  endfunction

  localparam int N_IN_D     = 4;
  localparam int EXACT_W_D  = 3;
  localparam int APPROX_W_D = 2;
  localparam int W_D        = max_w(EXACT_W_D, APPROX_W_D);
  localparam int CNT_W_D    = N_IN_D + 1;
  localparam int SUM_W_D    = sum_w(W_D, N_IN_D);
  localparam int SQ_W_D     = sq_w(W_D, N_IN_D);

endpackage

// File: rtl/err_metric_acc_if.sv
// Input pair handshake between a sweep source and the accumulator.
interface err_metric_acc_if #(
  parameter int EXACT_W  = 3,
  parameter int APPROX_W = 2
);
  logic                in_valid;
  logic                in_ready;
  logic                in_last;
  logic [EXACT_W-1:0]  exact;
  logic [APPROX_W-1:0] approx;

  modport master (
    output in_valid, in_last, exact, approx,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, exact, approx,
    output in_ready
  );
endinterface

// File: rtl/abs_err_calc.sv
// Combinational |zext(exact) - zext(approx)| in W bits.
module abs_err_calc
  import err_eval_pkg::*;
#(
  parameter  int EXACT_W  = EXACT_W_D,
  parameter  int APPROX_W = APPROX_W_D,
  localparam int W        = max_w(EXACT_W, APPROX_W)
) (
  input  logic [EXACT_W-1:0]  exact_i,
  input  logic [APPROX_W-1:0] approx_i,
  output logic [W-1:0]        err_o
);

  logic [W:0] ex;
  logic [W:0] ap;
  logic [W:0] pos;
  logic [W:0] neg;

  always_comb begin
    ex    = (W+1)'(exact_i);
    ap    = (W+1)'(approx_i);
    pos   = ex - ap;
    neg   = ap - ex;
    err_o = pos[W] ? neg[W-1:0] : pos[W-1:0];
  end

endmodule

// File: rtl/err_metric_acc.sv
// Sweep error-metric accumulator: count, max, sum of |exact-approx|.
// Define ERR_MSE_EN to add the sq_sum (sum of e*e) output.
module err_metric_acc
  import err_eval_pkg::*;
#(
  parameter  int N_IN     = N_IN_D,
  parameter  int EXACT_W  = EXACT_W_D,
  parameter  int APPROX_W = APPROX_W_D,
  localparam int W        = max_w(EXACT_W, APPROX_W),
  localparam int CNT_W    = N_IN + 1,
  localparam int SUM_W    = sum_w(W, N_IN),
  localparam int SQ_W     = sq_w(W, N_IN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  err_metric_acc_if.slave  in_if,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [W-1:0]     max_err,
  output logic [SUM_W-1:0] sum_err,
  output logic             ovf
`ifdef ERR_MSE_EN
  ,
  output logic [SQ_W-1:0]  sq_sum
`endif
);

  state_e state_q, state_d;

  logic             xfer;
  logic             full;
  logic             accept;
  logic             start_go;
  logic [W-1:0]     e_calc;

  logic [CNT_W-1:0] acc_cnt_q;
  logic             s1_vld_q;
  logic [W-1:0]     s1_e_q;
  logic             s1_nz_q;

  logic [CNT_W-1:0] vec_q;
  logic [CNT_W-1:0] err_q;
  logic [W-1:0]     max_q;
  logic [SUM_W-1:0] sum_q;
  logic             ovf_q;

  assign in_if.in_ready = (state_q == RUN);
  assign xfer     = in_if.in_valid & in_if.in_ready;
  assign full     = (acc_cnt_q == CNT_W'(2 ** N_IN));
  assign accept   = xfer & ~full;
  assign start_go = start & ((state_q == IDLE) | (state_q == DONE));

  abs_err_calc #(
    .EXACT_W  (EXACT_W),
    .APPROX_W (APPROX_W)
  ) u_abs (
    .exact_i  (in_if.exact),
    .approx_i (in_if.approx),
    .err_o    (e_calc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN:   if (xfer & (full | in_if.in_last)) state_d = FLUSH;
      FLUSH: if (!s1_vld_q) state_d = DONE;
      DONE:  if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Acceptance count runs ahead of vec_cnt so the overflow drop is decided at transfer time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
      s1_e_q    <= '0;
      s1_nz_q   <= 1'b0;
    end else if (start_go) begin
      acc_cnt_q <= '0;
      s1_vld_q  <= 1'b0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        s1_e_q    <= e_calc;
        s1_nz_q   <= |e_calc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (start_go) begin
      vec_q <= '0;
      err_q <= '0;
      max_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (xfer & full) ovf_q <= 1'b1;
      if (s1_vld_q) begin
        vec_q <= vec_q + CNT_W'(1);
        err_q <= err_q + CNT_W'(s1_nz_q);
        sum_q <= sum_q + SUM_W'(s1_e_q);
        if (s1_e_q > max_q) max_q <= s1_e_q;
      end
    end
  end

`ifdef ERR_MSE_EN
  logic [SQ_W-1:0] sq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sq_q <= '0;
    else if (start_go) sq_q <= '0;
    else if (s1_vld_q) sq_q <= sq_q + SQ_W'(s1_e_q) * SQ_W'(s1_e_q);
  end

  assign sq_sum = sq_q;
`endif

  assign done    = (state_q == DONE);
  assign vec_cnt = vec_q;
  assign err_cnt = err_q;
  assign max_err = max_q;
  assign sum_err = sum_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_err_metric_acc.sv
// Scoreboard bench for err_metric_acc with directed sweeps.
module tb_err_metric_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       done;
  logic [4:0] vec_cnt;
  logic [4:0] err_cnt;
  logic [2:0] max_err;
  logic [6:0] sum_err;
  logic       ovf;
`ifdef ERR_MSE_EN
  logic [9:0] sq_sum;
`endif

  err_metric_acc_if #(.EXACT_W(3), .APPROX_W(2)) bus ();

  err_metric_acc #(
    .N_IN     (4),
    .EXACT_W  (3),
    .APPROX_W (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in_if   (bus),
    .done    (done),
    .vec_cnt (vec_cnt),
    .err_cnt (err_cnt),
    .max_err (max_err),
    .sum_err (sum_err),
    .ovf     (ovf)
`ifdef ERR_MSE_EN
    ,
    .sq_sum  (sq_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int vec;
    int err;
    int mx;
    int sum;
    int ovf;
    int sq;
    bit lat;
  } exp_t;

  exp_t sbq[$];
  int   nchk = 0;
  int   nerr = 0;
  int   ncyc = 0;
  int   last_cyc = 0;
  bit   done_d = 1'b0;

  function automatic void chk(string nm, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic void push(int v, int e, int m, int s, int o, int q, bit l);
    exp_t x;
    x.vec = v; x.err = e; x.mx = m; x.sum = s;
    x.ovf = o; x.sq = q; x.lat = l;
    sbq.push_back(x);
  endfunction

  // Monitor: pops one expectation per rising done.
  always @(negedge clk) begin
    exp_t x;
    ncyc++;
    if (bus.in_valid && bus.in_ready && bus.in_last) last_cyc = ncyc;
    if (done && !done_d) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        x = sbq.pop_front();
        chk("vec_cnt", int'(vec_cnt), x.vec);
        chk("err_cnt", int'(err_cnt), x.err);
        chk("max_err", int'(max_err), x.mx);
        chk("sum_err", int'(sum_err), x.sum);
        chk("ovf", int'(ovf), x.ovf);
`ifdef ERR_MSE_EN
        chk("sq_sum", int'(sq_sum), x.sq);
`endif
        if (x.lat) chk("done_latency", ncyc - last_cyc, 3);
      end
    end
    done_d = done;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input int e, input int a, input bit last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.exact    = 3'(e);
    bus.approx   = 2'(a);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 0, 1);
        break;
      end
    end
    step();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    step();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_vec"}, int'(vec_cnt), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
    chk({tag, "_max"}, int'(max_err), 0);
    chk({tag, "_sum"}, int'(sum_err), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
`ifdef ERR_MSE_EN
    chk({tag, "_sq"}, int'(sq_sum), 0);
`endif
  endtask

  int ge[6] = '{7, 4, 2, 6, 0, 1};
  int ga[6] = '{0, 3, 2, 1, 3, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.exact    = '0;
    bus.approx   = '0;
    repeat (3) step();
    chk_zero("rst");
    chk("rst_ready", int'(bus.in_ready), 0);
    rst_n = 1'b1;
    step();

    // Reset mid-sweep after 5 erroneous vectors
    pulse_start();
    chk("start_ready", int'(bus.in_ready), 1);
    for (int i = 0; i < 5; i++) send(6, 1, 1'b0);
    idle();
    step();
    chk("pre_rst_vec", int'(vec_cnt), 5);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_ready", int'(bus.in_ready), 0);
    step();
    rst_n = 1'b1;
    step();

    // 16 exact matches, last on 16th
    push(16, 0, 0, 0, 0, 0, 1'b1);
    pulse_start();
    for (int i = 0; i < 16; i++) send(i % 4, i % 4, i == 15);
    idle();
    wait_done();

    // Three pairs, each error 2
    push(3, 3, 2, 6, 0, 12, 1'b1);
    pulse_start();
    send(3, 1, 1'b0);
    send(0, 2, 1'b0);
    send(5, 3, 1'b1);
    idle();
    wait_done();

    // 17 pairs with no last: 17th dropped
    push(16, 16, 1, 16, 1, 16, 1'b0);
    pulse_start();
    for (int i = 0; i < 17; i++) send(1, 0, 1'b0);
    idle();
    wait_done();

    // Back-to-back reference run
    push(6, 4, 7, 16, 0, 84, 1'b1);
    pulse_start();
    for (int i = 0; i < 6; i++) send(ge[i], ga[i], i == 5);
    idle();
    wait_done();

    // Same data, gappy, with start pulsed in RUN
    push(6, 4, 7, 16, 0, 84, 1'b1);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      send(ge[i], ga[i], i == 5);
      idle();
      if (i == 2) pulse_start();
      else if (i < 5) step();
    end
    wait_done();

    // start in DONE clears next cycle
    chk("pre_clear_done", int'(done), 1);
    pulse_start();
    chk_zero("clr");
    chk("clr_ready", int'(bus.in_ready), 1);
    push(2, 1, 5, 5, 0, 25, 1'b1);
    send(5, 0, 1'b0);
    send(3, 3, 1'b1);
    idle();
    wait_done();

    repeat (3) step();
    chk("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
